matvec_loader: RTL and testbench

Serial-to-parallel frame loader that sits directly upstream of the combinational 4x4 matrix-vector multiplier in the Kalman filter datapath. Accepts one signed WIDTH-bit word per beat over a valid/ready stream and assembles a full matrix A (row-major) followed by vector B. It presents both as stable parallel arrays with a level out_valid, held until the consumer acknowledges. A capture bank and an output bank let the next frame load while the current one is being consumed.

---
 rtl/matvec_loader_if.sv | 36 +++
 rtl/matvec_loader.sv | 125 ++++++++++++
 tb/tb_matvec_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matvec_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : matvec_loader_if
// Brief    : Stream-in / parallel-frame-out bundle for the matrix-vector loader.
// Revision : 1.0 - initial release
// ============================================================================
interface matvec_loader_if #(
    parameter int WIDTH = 16,
    parameter int NOS   = 4
);
    localparam int c_FRAME = NOS * NOS + NOS;
    localparam int c_IDX_W = $clog2(c_FRAME);

    logic                                   flush;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [WIDTH-1:0]                       in_data;
    logic [NOS-1:0][NOS-1:0][WIDTH-1:0]     A_out;
    logic [NOS-1:0][WIDTH-1:0]              B_out;
    logic                                   out_valid;
    logic                                   out_ack;
    logic [c_IDX_W-1:0]                     load_idx;

    // Loader side
    modport slave (
        input  flush, in_valid, in_data, out_ack,
        output in_ready, A_out, B_out, out_valid, load_idx
    );

    // Producer / consumer side
    modport master (
        output flush, in_valid, in_data, out_ack,
        input  in_ready, A_out, B_out, out_valid, load_idx
    );
endinterface
`default_nettype wire

// File: rtl/matvec_loader.sv
`default_nettype none
// ============================================================================
// Module   : matvec_loader
// Brief    : Serial-to-parallel loader: assembles matrix A (row-major) then
//            vector B into a capture bank, hands complete frames to an output bank.
// Revision : 1.0 - initial release
// ============================================================================
module matvec_loader #(
    parameter int WIDTH = 16,
    parameter int NOS   = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    matvec_loader_if.slave  bus
);
    localparam int c_FRAME = NOS * NOS + NOS;
    localparam int c_IDX_W = $clog2(c_FRAME);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_FRAME - 1);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [c_IDX_W-1:0]             r_idx;
    logic [c_IDX_W-1:0]             w_idx_nxt;
    logic                           r_out_valid;
    logic                           w_out_valid_nxt;
    logic                           w_ready;
    logic                           w_beat;
    logic                           w_xfer;
    // Flat banks: words 0..NOS*NOS-1 are A row-major, the rest are B.
    logic [c_FRAME-1:0][WIDTH-1:0]  r_cap;
    logic [c_FRAME-1:0][WIDTH-1:0]  r_out;

    // in_ready is purely a state decode, forced low while reset is held.
    assign w_ready = rst_n && (r_state == S_LOAD);
    assign w_beat  = bus.in_valid && w_ready && !bus.flush;
    assign w_xfer  = (r_state == S_FULL) && !bus.flush && (!r_out_valid || bus.out_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_valid_nxt = r_out_valid;

        // A transfer in the same cycle as an ack keeps the slot occupied.
        if (r_out_valid && bus.out_ack) begin
            w_out_valid_nxt = 1'b0;
        end
        if (w_xfer) begin
            w_out_valid_nxt = 1'b1;
        end

        if (bus.flush) begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_beat) begin
                        if (r_idx == c_LAST) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = S_FULL;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (w_xfer) begin
                        w_state_nxt = S_LOAD;
                    end
                end
                default: begin
                    w_state_nxt = S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap <= '0;
            r_out <= '0;
        end else begin
            if (w_beat) begin
                r_cap[r_idx] <= bus.in_data;
            end
            if (w_xfer) begin
                r_out <= r_cap;
            end
        end
    end

    generate
        for (genvar i = 0; i < NOS; i++) begin : g_row
            for (genvar k = 0; k < NOS; k++) begin : g_col
                assign bus.A_out[i][k] = r_out[i*NOS + k];
            end
        end
        for (genvar k = 0; k < NOS; k++) begin : g_vec
            assign bus.B_out[k] = r_out[NOS*NOS + k];
        end
    endgenerate

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.load_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_matvec_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matvec_loader
// Brief    : Scoreboard bench for matvec_loader with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matvec_loader;
    localparam int W     = 16;
    localparam int N     = 4;
    localparam int FRAME = N * N + N;

    typedef logic [FRAME-1:0][W-1:0] frame_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matvec_loader_if #(.WIDTH(W), .NOS(N)) bus ();

    matvec_loader #(.WIDTH(W), .NOS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     n_tests     = 0;
    int     n_fail      = 0;
    int     frames_seen = 0;
    bit     auto_ack    = 1'b0;
    frame_t exp_q[$];
    frame_t cur;
    int     cur_cnt     = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic frame_t grab();
        frame_t f;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                f[i*N + k] = bus.A_out[i][k];
        for (int k = 0; k < N; k++)
            f[N*N + k] = bus.B_out[k];
        return f;
    endfunction

    // One clock of stimulus; the model collects accepted words into frames.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit fl, output bit acc);
        @(negedge clk);
        if (auto_ack) bus.out_ack = bus.out_valid;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = fl;
        acc = v && bus.in_ready && !fl && rst_n;
        if (fl) cur_cnt = 0;
        if (acc) begin
            cur[cur_cnt] = d;
            cur_cnt++;
            if (cur_cnt == FRAME) begin
                exp_q.push_back(cur);
                cur_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, '0, 1'b0, acc);
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit gaps);
        bit acc;
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            cycle(gaps ? 1'($urandom_range(0, 1)) : 1'b1, d, 1'b0, acc);
            done = acc;
        end
        if (!done) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input frame_t f, input bit gaps);
        for (int j = 0; j < FRAME; j++) send_word(f[j], gaps);
    endtask

    // Monitor: a new frame is presented when out_valid is high and the slot
    // was either empty or acknowledged at the previous edge.
    initial begin
        bit     vprev;
        frame_t got;
        frame_t last;
        frame_t e;
        vprev = 1'b0;
        last  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                vprev = 1'b0;
            end else begin
                got = grab();
                if (bus.out_valid && (!vprev || bus.out_ack)) begin
                    frames_seen++;
                    check_eq("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_tests++;
                        if (got !== e) begin
                            n_fail++;
                            $display("FAIL frame_data: got %h expected %h", got, e);
                        end
                    end
                    last = got;
                end else if (bus.out_valid) begin
                    n_tests++;
                    if (got !== last) begin
                        n_fail++;
                        $display("FAIL output_stable: got %h expected %h", got, last);
                    end
                end
                vprev = bus.out_valid;
            end
        end
    end

    initial begin
        frame_t f;
        bit     acc;
        bit     rdy;
        int     seen0;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        bus.out_ack  = 1'b0;

        // Reset state
        idle(3);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_load_idx", 32'(bus.load_idx), 32'd0);
        check_eq("rst_banks_nonzero", 32'((bus.A_out != '0) || (bus.B_out != '0)), 32'd0);
        rst_n = 1'b1;
        idle(1);
        check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Frame 1..20, no ack
        for (int j = 0; j < FRAME; j++) f[j] = W'(j + 1);
        send_frame(f, 1'b0);
        idle(1);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("full_out_valid", 32'(bus.out_valid), 32'd0);
        idle(1);
        rdy = bus.in_ready;
        check_eq("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("lat_in_ready", 32'(rdy), 32'd1);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                check_eq($sformatf("A1[%0d][%0d]", i, k), 32'(bus.A_out[i][k]), 32'(4*i + k + 1));
        for (int k = 0; k < N; k++)
            check_eq($sformatf("B1[%0d]", k), 32'(bus.B_out[k]), 32'(17 + k));
        idle(1);
        check_eq("ready_one_cycle_low", 32'(bus.in_ready), 32'd1);

        // Frame 101..120 while slot occupied
        for (int j = 0; j < FRAME; j++) f[j] = W'(101 + j);
        send_frame(f, 1'b0);
        for (int c = 0; c < 3; c++) begin
            idle(1);
            check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("hold_A00", 32'(bus.A_out[0][0]), 32'd1);
        end
        bus.out_ack = 1'b1;
        idle(1);
        bus.out_ack = 1'b0;
        check_eq("xfer_A00", 32'(bus.A_out[0][0]), 32'd101);
        check_eq("xfer_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("xfer_in_ready", 32'(bus.in_ready), 32'd1);

        // Release, then a frame of negative values
        bus.out_ack = 1'b1;
        idle(1);
        bus.out_ack = 1'b0;
        check_eq("ack_clears_valid", 32'(bus.out_valid), 32'd0);
        for (int j = 0; j < FRAME; j++) f[j] = W'($urandom);
        f[0] = 16'h8000;
        f[1] = 16'hFFFF;
        f[2] = 16'h8001;
        send_frame(f, 1'b0);
        idle(2);
        check_eq("neg_A00", 32'(bus.A_out[0][0]), 32'h8000);
        check_eq("neg_A01", 32'(bus.A_out[0][1]), 32'hFFFF);
        check_eq("neg_out_valid", 32'(bus.out_valid), 32'd1);

        // Flush after 7 beats with a word presented
        for (int j = 0; j < 7; j++) send_word(W'($urandom), 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b1, acc);
        idle(1);
        check_eq("flush_load_idx", 32'(bus.load_idx), 32'd0);
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("flush_bank_kept", 32'(bus.A_out[0][0]), 32'h8000);
        for (int j = 0; j < FRAME; j++) f[j] = W'(201 + j);
        send_frame(f, 1'b0);
        idle(2);
        check_eq("post_flush_full", 32'(bus.in_ready), 32'd0);
        bus.out_ack = 1'b1;
        idle(1);
        bus.out_ack = 1'b0;
        check_eq("post_flush_A00", 32'(bus.A_out[0][0]), 32'd201);
        check_eq("post_flush_A13", 32'(bus.A_out[1][3]), 32'd208);
        check_eq("post_flush_B0", 32'(bus.B_out[0]), 32'd217);
        check_eq("post_flush_B3", 32'(bus.B_out[3]), 32'd220);
        bus.out_ack = 1'b1;
        idle(1);
        bus.out_ack = 1'b0;

        // Three random frames with input gaps and automatic ack
        auto_ack = 1'b1;
        seen0    = frames_seen;
        for (int fr = 0; fr < 3; fr++) begin
            for (int j = 0; j < FRAME; j++) f[j] = W'($urandom);
            send_frame(f, 1'b1);
        end
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) idle(1);
        idle(3);
        auto_ack    = 1'b0;
        bus.out_ack = 1'b0;
        idle(1);
        check_eq("rand_frames_delivered", 32'(frames_seen - seen0), 32'd3);
        check_eq("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("rand_slot_released", 32'(bus.out_valid), 32'd0);

        // Reset while FULL with out_valid high
        for (int j = 0; j < FRAME; j++) f[j] = W'($urandom);
        send_frame(f, 1'b0);
        idle(2);
        for (int j = 0; j < FRAME; j++) f[j] = W'($urandom);
        send_frame(f, 1'b0);
        idle(1);
        check_eq("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        cur_cnt = 0;
        idle(1);
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_banks_nonzero", 32'((bus.A_out != '0) || (bus.B_out != '0)), 32'd0);
        check_eq("mid_rst_load_idx", 32'(bus.load_idx), 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        idle(1);
        check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        idle(3);
        check_eq("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
